// File: rtl/arith_control_fsm.sv
// Fetch/decode/write sequencer for the arithmetic-machine datapath; owns the PC.
// Optional ARITH_CTRL_PERF_EN adds retired-instruction and fetch-stall counters.
module arith_control_fsm #(
   parameter logic [31:0] RESET_PC  = 32'h0040_0000,
   parameter int unsigned FETCH_TMO = 16
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [29:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   output logic [31:0] pc,
   output logic [31:0] inst,
   output logic        wr_enable,
   output logic        rd_src,
   output logic [1:0]  alu_src2,
   output logic [2:0]  alu_op,
   output logic        except
`ifdef ARITH_CTRL_PERF_EN
   ,
   output logic [31:0] retired,
   output logic [31:0] stall_cycles
`endif
);

   localparam int unsigned TMO_W = (FETCH_TMO < 2) ? 1 : $clog2(FETCH_TMO + 1);

   localparam logic [2:0] ALU_ADD = 3'd2;
   localparam logic [2:0] ALU_SUB = 3'd3;
   localparam logic [2:0] ALU_AND = 3'd4;
   localparam logic [2:0] ALU_OR  = 3'd5;
   localparam logic [2:0] ALU_NOR = 3'd6;
   localparam logic [2:0] ALU_XOR = 3'd7;

   localparam logic [1:0] SRC2_RT   = 2'd0;
   localparam logic [1:0] SRC2_SEXT = 2'd1;
   localparam logic [1:0] SRC2_ZEXT = 2'd2;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_n;
   logic [31:0]        inst_n;
   logic [TMO_W-1:0]   tmo_cnt;
   logic               tmo_hit;
   logic               fetch_stall;

   logic               dec_legal;
   logic               dec_rd_src;
   logic [1:0]         dec_src2;
   logic [2:0]         dec_op;

   assign imem_addr = pc[31:2];

   // State register
   always_ff @(posedge clock) begin
      if (reset) state <= FETCH;
      else       state <= state_n;
   end

   // Next state; wr_enable doubles as the latched "decode was legal" flag in EXEC
   always_comb begin
      state_n     = state;
      inst_n      = inst;
      fetch_stall = (state == FETCH) && !imem_ack;
      tmo_hit     = (FETCH_TMO != 0) && ((32'(tmo_cnt) + 32'd1) == FETCH_TMO);
      case (state)
         FETCH: begin
            if (imem_ack) begin
               state_n = EXEC;
               inst_n  = imem_data;
            end else if (tmo_hit) begin
               state_n = HALT;
            end
         end
         EXEC:    state_n = wr_enable ? FETCH : HALT;
         HALT:    state_n = HALT;
         default: state_n = FETCH;
      endcase
   end

   // Decode of the instruction that will sit in the register next cycle
   always_comb begin
      dec_legal  = 1'b0;
      dec_rd_src = 1'b0;
      dec_src2   = SRC2_RT;
      dec_op     = 3'd0;
      case (inst_n[31:26])
         6'h00: begin
            dec_legal = 1'b1;
            case (inst_n[5:0])
               6'h20:   dec_op = ALU_ADD;
               6'h22:   dec_op = ALU_SUB;
               6'h24:   dec_op = ALU_AND;
               6'h25:   dec_op = ALU_OR;
               6'h27:   dec_op = ALU_NOR;
               6'h26:   dec_op = ALU_XOR;
               default: dec_legal = 1'b0;
            endcase
         end
         6'h08: begin
            dec_legal  = 1'b1;
            dec_rd_src = 1'b1;
            dec_src2   = SRC2_SEXT;
            dec_op     = ALU_ADD;
         end
         6'h0C, 6'h0D, 6'h0E: begin
            dec_legal  = 1'b1;
            dec_rd_src = 1'b1;
            dec_src2   = SRC2_ZEXT;
            case (inst_n[27:26])
               2'b00:   dec_op = ALU_AND;
               2'b01:   dec_op = ALU_OR;
               default: dec_op = ALU_XOR;
            endcase
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // Datapath registers and registered control outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         pc        <= RESET_PC;
         inst      <= 32'd0;
         imem_req  <= 1'b1;
         wr_enable <= 1'b0;
         rd_src    <= 1'b0;
         alu_src2  <= 2'd0;
         alu_op    <= 3'd0;
         except    <= 1'b0;
         tmo_cnt   <= '0;
      end else begin
         inst      <= inst_n;
         imem_req  <= (state_n == FETCH);
         wr_enable <= (state_n == EXEC) && dec_legal;
         rd_src    <= (state_n == EXEC) ? dec_rd_src : 1'b0;
         alu_src2  <= (state_n == EXEC) ? dec_src2 : 2'd0;
         alu_op    <= (state_n == EXEC) ? dec_op : 3'd0;
         if ((state == EXEC) && wr_enable) pc <= pc + 32'd4;
         if (((state == EXEC) && !wr_enable) || (fetch_stall && tmo_hit)) except <= 1'b1;
         tmo_cnt   <= fetch_stall ? tmo_cnt + TMO_W'(1) : '0;
      end
   end

`ifdef ARITH_CTRL_PERF_EN
   // Performance counters; both naturally freeze in HALT
   always_ff @(posedge clock) begin
      if (reset) begin
         retired      <= 32'd0;
         stall_cycles <= 32'd0;
      end else begin
         if ((state == EXEC) && wr_enable) retired <= retired + 32'd1;
         if (fetch_stall) stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_arith_control_fsm.sv
// Bench for arith_control_fsm: vector table through a scoreboard plus reset,
// timeout, PC-wrap and (with ARITH_CTRL_PERF_EN) counter sequences.
module tb_arith_control_fsm;

   localparam logic [31:0] RST_PC   = 32'h0040_0000;
   localparam logic [31:0] RST_PC_W = 32'hFFFF_FFFC;

   typedef struct {
      logic [31:0] word;
      int          waits;
      logic        legal;
      logic        rd_src;
      logic [1:0]  src2;
      logic [2:0]  op;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_data = 32'd0;
   logic        imem_req;
   logic [29:0] imem_addr;
   logic [31:0] pc, inst;
   logic        wr_enable, rd_src, except;
   logic [1:0]  alu_src2;
   logic [2:0]  alu_op;

   logic        ack_w = 1'b0;
   logic [31:0] data_w = 32'd0;
   logic        req_w;
   logic [29:0] addr_w;
   logic [31:0] pc_w, inst_w;
   logic        wr_w, rd_src_w, except_w;
   logic [1:0]  src2_w;
   logic [2:0]  op_w;
`ifdef ARITH_CTRL_PERF_EN
   logic [31:0] retired, stall_cycles, retired_w, stall_w;
   int          exp_retired, exp_stall;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_pc;
   vec_t        sb[$];
   vec_t        tbl[13];

   arith_control_fsm #(.RESET_PC(RST_PC), .FETCH_TMO(16)) dut (
      .clock(clock), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
      .pc(pc), .inst(inst), .wr_enable(wr_enable), .rd_src(rd_src),
      .alu_src2(alu_src2), .alu_op(alu_op), .except(except)
`ifdef ARITH_CTRL_PERF_EN
      , .retired(retired), .stall_cycles(stall_cycles)
`endif
   );

   arith_control_fsm #(.RESET_PC(RST_PC_W), .FETCH_TMO(16)) dut_w (
      .clock(clock), .reset(reset),
      .imem_req(req_w), .imem_addr(addr_w), .imem_ack(ack_w), .imem_data(data_w),
      .pc(pc_w), .inst(inst_w), .wr_enable(wr_w), .rd_src(rd_src_w),
      .alu_src2(src2_w), .alu_op(op_w), .except(except_w)
`ifdef ARITH_CTRL_PERF_EN
      , .retired(retired_w), .stall_cycles(stall_w)
`endif
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      imem_ack = 1'b0;
      ack_w    = 1'b0;
      tick();
      tick();
      reset  = 1'b0;
      exp_pc = RST_PC;
`ifdef ARITH_CTRL_PERF_EN
      exp_retired = 0;
      exp_stall   = 0;
`endif
   endtask

   // Fetch one word after v.waits unacknowledged cycles, then check EXEC and its aftermath
   task automatic run_vec(input vec_t v);
      vec_t e;
      for (int i = 0; i < v.waits; i++) begin
         check("req_wait", 32'(imem_req), 32'd1);
         tick();
      end
      check("req_fetch", 32'(imem_req), 32'd1);
      check("addr_fetch", 32'(imem_addr), 32'(exp_pc[31:2]));
      imem_ack  = 1'b1;
      imem_data = v.word;
      sb.push_back(v);
      tick();
      imem_ack  = 1'b0;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check("exec_wr", 32'(wr_enable), 32'(e.legal));
      check("exec_inst", inst, e.word);
      check("exec_pc", pc, exp_pc);
      check("exec_req", 32'(imem_req), 32'd0);
`ifdef ARITH_CTRL_PERF_EN
      exp_stall += e.waits;
`endif
      if (e.legal) begin
         check("exec_rd_src", 32'(rd_src), 32'(e.rd_src));
         check("exec_src2", 32'(alu_src2), 32'(e.src2));
         check("exec_op", 32'(alu_op), 32'(e.op));
         tick();
         exp_pc = exp_pc + 32'd4;
         check("post_wr", 32'(wr_enable), 32'd0);
         check("post_pc", pc, exp_pc);
         check("post_req", 32'(imem_req), 32'd1);
         check("post_op", 32'(alu_op), 32'd0);
         check("post_except", 32'(except), 32'd0);
`ifdef ARITH_CTRL_PERF_EN
         exp_retired++;
         check("perf_retired", retired, 32'(exp_retired));
         check("perf_stall", stall_cycles, 32'(exp_stall));
`endif
      end else begin
         tick();
         check("halt_except", 32'(except), 32'd1);
         check("halt_req", 32'(imem_req), 32'd0);
         check("halt_pc", pc, exp_pc);
         imem_ack = 1'b1;
         tick();
         tick();
         imem_ack = 1'b0;
         check("halt_ack_wr", 32'(wr_enable), 32'd0);
         check("halt_ack_req", 32'(imem_req), 32'd0);
         check("halt_ack_pc", pc, exp_pc);
         check("halt_sticky", 32'(except), 32'd1);
         do_reset();
         check("rst_after_halt_pc", pc, RST_PC);
         check("rst_after_halt_exc", 32'(except), 32'd0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{32'h0022_1820, 0, 1'b1, 1'b0, 2'd0, 3'd2};  // add
      tbl[1]  = '{32'h3405_FFFF, 3, 1'b1, 1'b1, 2'd2, 3'd5};  // ori, 3 waits
      tbl[2]  = '{32'h0022_2022, 1, 1'b1, 1'b0, 2'd0, 3'd3};  // sub
      tbl[3]  = '{32'h0022_2824, 0, 1'b1, 1'b0, 2'd0, 3'd4};  // and
      tbl[4]  = '{32'h0022_3025, 2, 1'b1, 1'b0, 2'd0, 3'd5};  // or
      tbl[5]  = '{32'h0022_3827, 0, 1'b1, 1'b0, 2'd0, 3'd6};  // nor
      tbl[6]  = '{32'h0022_4026, 1, 1'b1, 1'b0, 2'd0, 3'd7};  // xor
      tbl[7]  = '{32'h2001_0005, 0, 1'b1, 1'b1, 2'd1, 3'd2};  // addi
      tbl[8]  = '{32'h3002_000F, 2, 1'b1, 1'b1, 2'd2, 3'd4};  // andi
      tbl[9]  = '{32'h3803_0F0F, 0, 1'b1, 1'b1, 2'd2, 3'd7};  // xori
      tbl[10] = '{32'hFC00_0000, 0, 1'b0, 1'b0, 2'd0, 3'd0};  // illegal opcode
      tbl[11] = '{32'h0022_1821, 1, 1'b0, 1'b0, 2'd0, 3'd0};  // illegal funct
      tbl[12] = '{32'h8C01_0000, 0, 1'b0, 1'b0, 2'd0, 3'd0};  // lw, unsupported

      do_reset();
      check("rst_req", 32'(imem_req), 32'd1);
      check("rst_addr", 32'(imem_addr), 32'h0010_0000);
      check("rst_pc", pc, RST_PC);
      check("rst_inst", inst, 32'd0);
      check("rst_wr", 32'(wr_enable), 32'd0);
      check("rst_ctl", {27'd0, rd_src, alu_src2, alu_op}, 32'd0);
      check("rst_except", 32'(except), 32'd0);

      for (int i = 0; i < 13; i++) run_vec(tbl[i]);

      // Reset mid-fetch with an ack on the same edge: ack discarded
      do_reset();
      run_vec(tbl[0]);
      imem_ack  = 1'b1;
      imem_data = 32'h0022_1820;
      reset     = 1'b1;
      tick();
      reset     = 1'b0;
      imem_ack  = 1'b0;
      exp_pc    = RST_PC;
      check("midrst_pc", pc, RST_PC);
      check("midrst_inst", inst, 32'd0);
      check("midrst_req", 32'(imem_req), 32'd1);
      check("midrst_wr", 32'(wr_enable), 32'd0);
      tick();
      check("midrst_wr2", 32'(wr_enable), 32'd0);
      check("midrst_req2", 32'(imem_req), 32'd1);

      // Fetch timeout after 16 unacknowledged cycles
      do_reset();
      for (int i = 0; i < 15; i++) tick();
      check("tmo_15_except", 32'(except), 32'd0);
      check("tmo_15_req", 32'(imem_req), 32'd1);
      tick();
      check("tmo_16_except", 32'(except), 32'd1);
      check("tmo_16_req", 32'(imem_req), 32'd0);
      check("tmo_pc", pc, RST_PC);
      do_reset();
      check("tmo_rst_except", 32'(except), 32'd0);
      check("tmo_rst_pc", pc, RST_PC);
      check("tmo_rst_req", 32'(imem_req), 32'd1);

      // PC wrap on the second instance
      do_reset();
      ack_w  = 1'b1;
      data_w = 32'h2001_0005;
      tick();
      ack_w  = 1'b0;
      check("wrap_wr", 32'(wr_w), 32'd1);
      check("wrap_pc_exec", pc_w, RST_PC_W);
      tick();
      check("wrap_pc", pc_w, 32'd0);
      check("wrap_addr", 32'(addr_w), 32'd0);
      check("wrap_req", 32'(req_w), 32'd1);

`ifdef ARITH_CTRL_PERF_EN
      do_reset();
      for (int i = 0; i < 3; i++) run_vec('{32'h0022_1820, 2, 1'b1, 1'b0, 2'd0, 3'd2});
      check("perf3_retired", retired, 32'd3);
      check("perf3_stall", stall_cycles, 32'd6);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
